uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver that feeds the byte FIFO on the RX side of the link.
//  Oversamples the asynchronous rx line at 16x the bit rate and deframes
//  8N1-style frames (start, DBIT data bits LSB first, stop).
//  For each good frame it raises a one-clock strobe with the byte, driving
//  the FIFO's w_data/wr directly. Baud tick generator is internal.
// PARAMETERS
//  DBIT      8    data bits per frame
//  SB_TICK   16   oversample ticks in the stop bit (16 = 1 stop bit)
//  BAUD_DIV  326  clk cycles per oversample tick (50 MHz / (9600*16))
// PORTS
//  clk           in   1     system clock, all logic on posedge
//  rst_n         in   1     asynchronous reset, active low
//  rx            in   1     serial line, idle high, asynchronous to clk
//  rx_data       out  DBIT  last correctly received word (connects to w_data)
//  rx_done_tick  out  1     one-clk strobe, rx_data valid (connects to wr)
//  frame_err     out  1     one-clk strobe, stop bit sampled low
// BEHAVIOUR
//  Clocking and reset: one clock, clk. rst_n is asynchronous and active low.
//  Reset: state=IDLE; s,n,baud counters=0; rx_data=0; rx_done_tick=0;
//   frame_err=0; both synchronizer flops=1. Takes effect immediately.
//  Synchronizer: rx passes through 2 flops -> rx_s. The FSM uses only rx_s.
//  Baud gen: free-running counter 0..BAUD_DIV-1. tick=1 for one clk when
//   the counter equals BAUD_DIV-1, then it wraps to 0. It never stops.
//  Counters: s (4b) counts ticks within a bit; n (log2 DBIT) counts bits;
//   b (DBIT) is the shift register.
//  FSM states and transitions:
//   IDLE: rx_s==0 -> START with s=0 (checked every clk, not only on tick).
//   START: on tick, if s==7: rx_s==0 -> DATA with s=0, n=0;
//    rx_s==1 -> IDLE (glitch, no outputs). Otherwise s++.
//   DATA: on tick, if s==15: s=0, b={rx_s,b[DBIT-1:1]}.
//    If n==DBIT-1 -> STOP, else n++. Otherwise s++.
//   STOP: on tick, if s==SB_TICK-1:
//    rx_s==1 -> IDLE, rx_data<=b, rx_done_tick=1.
//    rx_s==0 -> WAIT_HI, frame_err=1, rx_data unchanged. Otherwise s++.
//   WAIT_HI: stay until rx_s==1, then -> IDLE. A break/stuck-low line
//    produces no further events.
//  Outputs: all registered. rx_data and rx_done_tick update on the same
//   edge, so the FIFO samples them together on the next edge.
//   rx_done_tick and frame_err are never high together and are each exactly
//   1 clk wide. rx_data holds its value between frames.
//  Latency: rx_done_tick rises about (DBIT+1.5) bit times + 3 clk after the
//   start-bit falling edge on rx (mid-stop sample).
//  Back-to-back: a start edge seen in IDLE right after STOP is accepted.
//   No idle gap is required.
//  Jitter: a free-running tick gives <=1/16 bit sample-phase error.
//   This is acceptable by design.
//  Reset mid-frame: the partial frame is discarded and no strobe is issued.
//   After release, reception restarts at the next falling edge.
// TESTING  (bench uses BAUD_DIV=2 -> 32 clk per bit, SB_TICK=16, DBIT=8)
//  1. Frame 0xA5 with a valid stop -> exactly one rx_done_tick,
//     rx_data=8'hA5, frame_err stays 0.
//  2. Frames 0x00 then 0xFF back-to-back, no gap -> two strobes,
//     rx_data 8'h00 then 8'hFF, in order.
//  3. rx pulled low for 6 clk then high -> returns to IDLE, no strobe,
//     rx_data unchanged; a following 0x3C frame is received correctly.
//  4. Frame 0x3C with stop bit 0, line held low 5 bit times -> one frame_err
//     pulse, no rx_done_tick, rx_data keeps its prior value; after the line
//     goes high, next 0x81 frame gives rx_data=8'h81.
//  5. rst_n asserted during DATA bit 4 -> outputs 0 immediately, no strobe;
//     after release, frame 0x5A gives rx_data=8'h5A.
//  6. Connected to the FIFO: send 0x11,0x22,0x33 -> FIFO empty deasserts
//     after the first strobe, and all three words are stored.

Source files
------------

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: two-flop synchronizer, free-running baud
// tick, start/data/stop deframing with registered byte strobe and frame error.
module uart_rx #(
   parameter int DBIT     = 8,
   parameter int SB_TICK  = 16,
   parameter int BAUD_DIV = 326
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_done_tick,
   output logic            frame_err
);

   // state    | meaning
   // IDLE     | line idle, waiting for rx_s low
   // START    | confirming start bit at its middle (8 ticks)
   // DATA     | sampling DBIT data bits, LSB first, every 16 ticks
   // STOP     | sampling stop bit after SB_TICK ticks
   // WAIT_HI  | stop bit was low; wait for line to return high
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_WAIT_HI = 3'd4
   } state_t;

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
   localparam logic [3:0]    S_MID     = 4'd7;
   localparam logic [3:0]    S_LAST    = 4'd15;
   localparam logic [3:0]    S_STOP    = 4'(SB_TICK - 1);

   logic [BW-1:0]   r_baud_cnt;
   logic            w_tick;
   logic            r_sync1;
   logic            r_sync2;
   logic            w_rx_s;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_s;
   logic [3:0]      w_s_nxt;
   logic [NW-1:0]   r_n;
   logic [NW-1:0]   w_n_nxt;
   logic [DBIT-1:0] r_b;
   logic [DBIT-1:0] w_b_nxt;
   logic [DBIT:0]   w_b_shift;

   logic            w_stop_sample;
   logic            w_done_set;
   logic            w_ferr_set;

   // Baud tick generator: never gated, so sample phase error is <= 1/16 bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud_cnt <= '0;
      end else if (w_tick) begin
         r_baud_cnt <= '0;
      end else begin
         r_baud_cnt <= r_baud_cnt + 1'b1;
      end
   end

   assign w_tick = (r_baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s = r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_n     <= w_n_nxt;
         r_b     <= w_b_nxt;
      end
   end

   // Concatenate-and-drop keeps the shift legal even when DBIT is 1.
   assign w_b_shift = {w_rx_s, r_b};

   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_n_nxt     = r_n;
      w_b_nxt     = r_b;
      case (r_state)
         ST_IDLE: begin
            if (!w_rx_s) begin
               w_state_nxt = ST_START;
               w_s_nxt     = '0;
            end
         end
         ST_START: begin
            if (w_tick) begin
               if (r_s == S_MID) begin
                  if (!w_rx_s) begin
                     w_state_nxt = ST_DATA;
                     w_s_nxt     = '0;
                     w_n_nxt     = '0;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_s_nxt = r_s + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_s == S_LAST) begin
                  w_s_nxt = '0;
                  w_b_nxt = w_b_shift[DBIT:1];
                  if (r_n == N_LAST) begin
                     w_state_nxt = ST_STOP;
                  end else begin
                     w_n_nxt = r_n + 1'b1;
                  end
               end else begin
                  w_s_nxt = r_s + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               if (r_s == S_STOP) begin
                  w_state_nxt = w_rx_s ? ST_IDLE : ST_WAIT_HI;
               end else begin
                  w_s_nxt = r_s + 4'd1;
               end
            end
         end
         ST_WAIT_HI: begin
            if (w_rx_s) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_stop_sample = (r_state == ST_STOP) && w_tick && (r_s == S_STOP);
      w_done_set    = w_stop_sample && w_rx_s;
      w_ferr_set    = w_stop_sample && !w_rx_s;
   end

   // Data and strobe load on the same edge so the FIFO captures them together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data      <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_done_tick <= w_done_set;
         frame_err    <= w_ferr_set;
         if (w_done_set) begin
            rx_data <= r_b;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus random frames against a frame-level
// model (expected byte/err per frame), with hand sequences for glitch/reset/FIFO.
module tb_uart_rx;

   localparam int DBIT     = 8;
   localparam int SB_TICK  = 16;
   localparam int BAUD_DIV = 2;
   localparam int BIT_CLK  = 16 * BAUD_DIV;

   logic            clk;
   logic            rst_n;
   logic            rx;
   logic [DBIT-1:0] rx_data;
   logic            rx_done_tick;
   logic            frame_err;

   uart_rx #(
      .DBIT     (DBIT),
      .SB_TICK  (SB_TICK),
      .BAUD_DIV (BAUD_DIV)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .rx_data      (rx_data),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      bit         stop;
      int         low_bits;
      int         gap;
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   int         n_vec = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] got_q[$];
   logic [7:0] model_data;
   bit         prev_done = 1'b0;
   bit         prev_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Collects strobes as the FIFO would see them and checks pulse shape.
   always @(negedge clk) begin
      if (rx_done_tick) begin
         got_q.push_back(rx_data);
         done_cnt++;
      end
      if (frame_err) err_cnt++;
      if (rx_done_tick || frame_err) begin
         check("strobe_exclusive", {31'd0, rx_done_tick & frame_err}, 32'd0);
         check("strobe_width", {31'd0, (rx_done_tick & prev_done) | (frame_err & prev_err)}, 32'd0);
      end
      prev_done = rx_done_tick;
      prev_err  = frame_err;
   end

   task automatic drive(input logic v, input int ncyc);
      rx = v;
      repeat (ncyc) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop, input int low_bits, input int gap);
      drive(1'b0, BIT_CLK);
      for (int i = 0; i < DBIT; i++) drive(d[i], BIT_CLK);
      if (stop) drive(1'b1, BIT_CLK);
      else      drive(1'b0, BIT_CLK * low_bits);
      drive(1'b1, gap);
   endtask

   // The stop sample lands before the frame ends, so each frame's events are
   // visible by the time send_frame returns.
   task automatic apply_vec(input vec_t v);
      int d0;
      int e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(v.data, v.stop, v.low_bits, v.gap);
      if (v.exp_done) model_data = v.data;
      check("done_count", done_cnt - d0, {31'd0, v.exp_done});
      check("ferr_count", err_cnt - e0, {31'd0, v.exp_err});
      check("rx_data", {24'd0, rx_data}, {24'd0, model_data});
      if (v.exp_done && got_q.size() > 0)
         check("strobe_byte", {24'd0, got_q[$]}, {24'd0, v.data});
   endtask

   vec_t tbl[7];
   vec_t rv;

   initial begin
      tbl[0] = '{data: 8'hA5, stop: 1'b1, low_bits: 0, gap: 32, exp_done: 1'b1, exp_err: 1'b0};
      tbl[1] = '{data: 8'h00, stop: 1'b1, low_bits: 0, gap: 0,  exp_done: 1'b1, exp_err: 1'b0};
      tbl[2] = '{data: 8'hFF, stop: 1'b1, low_bits: 0, gap: 64, exp_done: 1'b1, exp_err: 1'b0};
      tbl[3] = '{data: 8'h3C, stop: 1'b0, low_bits: 5, gap: 64, exp_done: 1'b0, exp_err: 1'b1};
      tbl[4] = '{data: 8'h81, stop: 1'b1, low_bits: 0, gap: 32, exp_done: 1'b1, exp_err: 1'b0};
      tbl[5] = '{data: 8'hC3, stop: 1'b0, low_bits: 1, gap: 32, exp_done: 1'b0, exp_err: 1'b1};
      tbl[6] = '{data: 8'h7E, stop: 1'b1, low_bits: 0, gap: 0,  exp_done: 1'b1, exp_err: 1'b0};

      model_data = 8'h00;
      rx    = 1'b1;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_done", {31'd0, rx_done_tick}, 32'd0);
      check("reset_ferr", {31'd0, frame_err}, 32'd0);
      rst_n = 1'b1;
      drive(1'b1, 2 * BIT_CLK);

      for (int i = 0; i < 7; i++) apply_vec(tbl[i]);
      if (got_q.size() >= 4) begin
         check("b2b_first", {24'd0, got_q[1]}, 32'h00);
         check("b2b_second", {24'd0, got_q[2]}, 32'hFF);
      end else begin
         check("b2b_count", got_q.size(), 32'd5);
      end

      begin : glitch
         int d0;
         int e0;
         d0 = done_cnt;
         e0 = err_cnt;
         drive(1'b0, 6);
         drive(1'b1, 2 * BIT_CLK);
         check("glitch_done", done_cnt - d0, 32'd0);
         check("glitch_ferr", err_cnt - e0, 32'd0);
         check("glitch_rx_data", {24'd0, rx_data}, {24'd0, model_data});
      end
      rv = '{data: 8'h3C, stop: 1'b1, low_bits: 0, gap: 32, exp_done: 1'b1, exp_err: 1'b0};
      apply_vec(rv);

      begin : mid_reset
         int d0;
         int e0;
         logic [7:0] d;
         d = 8'hE7;
         drive(1'b0, BIT_CLK);
         for (int i = 0; i < 4; i++) drive(d[i], BIT_CLK);
         drive(d[4], BIT_CLK / 2);
         d0 = done_cnt;
         e0 = err_cnt;
         #2;
         rst_n = 1'b0;
         rx    = 1'b1;
         #1;
         model_data = 8'h00;
         check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
         check("midrst_done", {31'd0, rx_done_tick}, 32'd0);
         check("midrst_ferr", {31'd0, frame_err}, 32'd0);
         repeat (10) @(negedge clk);
         rst_n = 1'b1;
         drive(1'b1, 12 * BIT_CLK);
         check("midrst_no_done", done_cnt - d0, 32'd0);
         check("midrst_no_ferr", err_cnt - e0, 32'd0);
         check("midrst_hold", {24'd0, rx_data}, 32'd0);
      end
      rv = '{data: 8'h5A, stop: 1'b1, low_bits: 0, gap: 32, exp_done: 1'b1, exp_err: 1'b0};
      apply_vec(rv);

      got_q.delete();
      check("fifo_empty_before", got_q.size(), 32'd0);
      send_frame(8'h11, 1'b1, 0, 0);
      check("fifo_after_first", got_q.size(), 32'd1);
      send_frame(8'h22, 1'b1, 0, 0);
      send_frame(8'h33, 1'b1, 0, 32);
      model_data = 8'h33;
      check("fifo_count", got_q.size(), 32'd3);
      if (got_q.size() == 3) begin
         check("fifo_w0", {24'd0, got_q[0]}, 32'h11);
         check("fifo_w1", {24'd0, got_q[1]}, 32'h22);
         check("fifo_w2", {24'd0, got_q[2]}, 32'h33);
      end

      for (int i = 0; i < 24; i++) begin
         rv.data     = 8'($urandom_range(0, 255));
         rv.stop     = ($urandom_range(0, 5) != 0);
         rv.low_bits = rv.stop ? 0 : int'($urandom_range(1, 3));
         rv.gap      = rv.stop ? int'($urandom_range(0, 2)) * 16 : 32 + int'($urandom_range(0, 32));
         rv.exp_done = rv.stop;
         rv.exp_err  = !rv.stop;
         apply_vec(rv);
      end

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
